soc_log_ram: RTL and testbench

SOC_LOG_RAM -- requirements
Module: soc_log_ram

---
 rtl/soc_log_ram.sv | 115 +++++++++++
 tb/tb_soc_log_ram.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_log_ram.sv
// soc_log_ram: session sample logger into a RAM with in-order, back-pressured dump
module soc_log_ram #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 10,
    parameter int WRAP    = 0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               in_ready,
    input  logic               dump_req,
    output logic               dump_valid,
    output logic [D_WIDTH-1:0] dump_data,
    input  logic               dump_ready,
    output logic               dump_last,
    output logic [A_WIDTH:0]   count,
    output logic               overflow,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, LOG, DUMP} state_t;
    localparam logic [A_WIDTH:0] FULL = {1'b1, {A_WIDTH{1'b0}}};
    state_t state_q, state_d;
    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0] count_q, count_d, left_q, left_d;
    logic overflow_q, overflow_d, dump_valid_q, dump_valid_d, dump_last_q, dump_last_d;
    logic [D_WIDTH-1:0] mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] rd_data_q;
    logic full, wr_en, rd_en, adv;
    // next state: session control, write pointer/count, and the dump read pipeline
    always_comb begin
        full = count_q == FULL;
        in_ready = state_q == LOG && (WRAP != 0 || !full);
        wr_en = in_valid && in_ready;
        adv = !dump_valid_q || dump_ready;
        rd_en = state_q == DUMP && adv && left_q != '0;
        state_d = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d = count_q;
        left_d = left_q;
        overflow_d = overflow_q;
        dump_valid_d = dump_valid_q;
        dump_last_d = dump_last_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOG;
                    wr_ptr_d = '0;
                    count_d = '0;
                    overflow_d = 1'b0;
                end else if (dump_req && count_q != '0) begin
                    state_d = DUMP;
                    rd_ptr_d = wr_ptr_q - count_q[A_WIDTH-1:0];
                    left_d = count_q;
                end
            end
            LOG: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
                    count_d = full ? count_q : count_q + (A_WIDTH+1)'(1);
                end
                if (in_valid && full) overflow_d = 1'b1;
                if (stop) state_d = IDLE;
            end
            DUMP: begin
                if (adv) begin
                    dump_valid_d = left_q != '0;
                    dump_last_d = left_q == (A_WIDTH+1)'(1);
                    if (rd_en) begin
                        rd_ptr_d = rd_ptr_q + A_WIDTH'(1);
                        left_d = left_q - (A_WIDTH+1)'(1);
                    end
                    if (dump_valid_q && dump_last_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // sample RAM: single write port, registered read that holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_data;
        if (rd_en) rd_data_q <= mem[rd_ptr_q];
    end
    // control state registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            left_q <= '0;
            overflow_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            left_q <= left_d;
            overflow_q <= overflow_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q <= dump_last_d;
        end
    end
    assign dump_valid = dump_valid_q;
    assign dump_last = dump_last_q;
    assign dump_data = dump_valid_q ? rd_data_q : '0;
    assign count = count_q;
    assign overflow = overflow_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_soc_log_ram.sv
// tb_soc_log_ram: random and directed checks of stop-when-full and wrap loggers against a queue model
module tb_soc_log_ram;
    logic clk = 0, n_rst = 1, start = 0, stop = 0, in_valid = 0, dump_req = 0, dump_ready = 0;
    logic [15:0] in_data = 0;
    logic [1:0] ir, dv, dl, ov, bz;
    logic [15:0] dd [2];
    logic [2:0] cnt [2];
    int pass = 0, total = 0;
    logic [15:0] mq0[$], mq1[$];
    bit mlog;
    bit mov [2];

    soc_log_ram #(.D_WIDTH(16), .A_WIDTH(2), .WRAP(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .in_valid(in_valid),
        .in_data(in_data), .in_ready(ir[0]), .dump_req(dump_req), .dump_valid(dv[0]),
        .dump_data(dd[0]), .dump_ready(dump_ready), .dump_last(dl[0]), .count(cnt[0]),
        .overflow(ov[0]), .busy(bz[0]));
    soc_log_ram #(.D_WIDTH(16), .A_WIDTH(2), .WRAP(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .in_valid(in_valid),
        .in_data(in_data), .in_ready(ir[1]), .dump_req(dump_req), .dump_valid(dv[1]),
        .dump_data(dd[1]), .dump_ready(dump_ready), .dump_last(dl[1]), .count(cnt[1]),
        .overflow(ov[1]), .busy(bz[1]));

    always #5 clk = ~clk;

    function automatic int exp_n(int k);
        return k == 0 ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [15:0] exp_w(int k, int i);
        return k == 0 ? mq0[i] : mq1[i];
    endfunction

    task automatic do_start(input bit stp);
        @(negedge clk);
        start = 1; stop = stp; in_valid = 0; dump_req = 0;
        if (!stp) begin
            mlog = 1; mq0.delete(); mq1.delete(); mov[0] = 0; mov[1] = 0;
        end
        @(negedge clk);
        start = 0; stop = 0;
    endtask

    task automatic send(input logic [15:0] d, input bit v, input bit stp);
        @(negedge clk);
        in_valid = v; in_data = d; stop = stp; start = 0; dump_req = 1'($urandom_range(0, 1));
        for (int k = 0; k < 2; k++) begin
            bit er = mlog && (k == 1 || exp_n(k) < 4);
            total++;
            if (ir[k] !== er) $display("FAIL in_ready[%0d]: got %b want %b", k, ir[k], er);
            else pass++;
        end
        if (v && mlog) begin
            if (mq0.size() < 4) mq0.push_back(d);
            else mov[0] = 1;
            if (mq1.size() == 4) begin
                void'(mq1.pop_front());
                mov[1] = 1;
            end
            mq1.push_back(d);
        end
        if (stp) mlog = 0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        in_valid = 0; stop = 1; dump_req = 0; mlog = 0;
        @(negedge clk);
        stop = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (bz[k] !== 1'b0) $display("FAIL busy_after_stop[%0d]: got %b want 0", k, bz[k]);
            else pass++;
        end
    endtask

    task automatic test_reset();
        #2 n_rst = 0;
        #10;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({ir[k], dv[k], dl[k], ov[k], bz[k], dd[k], cnt[k]} !== '0)
                $display("FAIL reset_outputs[%0d]: got %b want 0", k, {ir[k], dv[k], dl[k], ov[k], bz[k], dd[k], cnt[k]});
            else pass++;
        end
        @(negedge clk) n_rst = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (bz[k] !== 0 || cnt[k] !== 0) $display("FAIL post_reset[%0d]: busy %b count %0d want 0 0", k, bz[k], cnt[k]);
            else pass++;
        end
    endtask

    task automatic test_dump(input int mode);
        int ik [2];
        bit fin, done;
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        ik[0] = 0; ik[1] = 0; fin = 0; done = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt[k] !== 3'(exp_n(k)) || ov[k] !== mov[k])
                $display("FAIL pre_dump_status[%0d]: count %0d ovf %b want %0d %b", k, cnt[k], ov[k], exp_n(k), mov[k]);
            else pass++;
        end
        @(negedge clk);
        dump_req = 1; dump_ready = 1;
        for (int c = 1; c < 64; c++) begin
            @(negedge clk);
            dump_req = 0;
            start = c == 3 && exp_n(0) >= 3;
            in_valid = 1; in_data = 16'($urandom);
            dump_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : c >= 2 ? 1'(pat[(c-2)%7]) : 1'b1;
            for (int k = 0; k < 2; k++) begin
                int n = exp_n(k);
                bit ev = n > 0 && c >= 2 && ik[k] < n;
                total++;
                if (dv[k] !== ev || bz[k] !== (n > 0 && ik[k] < n) || ir[k] !== 1'b0)
                    $display("FAIL dump_ctrl[%0d] c%0d: valid %b busy %b in_ready %b want %b %b 0", k, c, dv[k], bz[k], ir[k], ev, n > 0 && ik[k] < n);
                else pass++;
                if (ev) begin
                    total++;
                    if (dd[k] !== exp_w(k, ik[k]) || dl[k] !== (ik[k] == n - 1))
                        $display("FAIL dump_word[%0d] #%0d: data %h last %b want %h %b", k, ik[k], dd[k], dl[k], exp_w(k, ik[k]), ik[k] == n - 1);
                    else pass++;
                    if (dump_ready) ik[k]++;
                end
            end
            done = ik[0] == exp_n(0) && ik[1] == exp_n(1);
            if (done && fin && c >= 4) break;
            if (done) fin = 1;
        end
        start = 0; in_valid = 0; dump_ready = 0;
        total++;
        if (!(done && fin)) $display("FAIL dump_timeout: delivered %0d/%0d %0d/%0d", ik[0], exp_n(0), ik[1], exp_n(1));
        else pass++;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt[k] !== 3'(exp_n(k)) || ov[k] !== mov[k])
                $display("FAIL post_dump_status[%0d]: count %0d ovf %b want %0d %b", k, cnt[k], ov[k], exp_n(k), mov[k]);
            else pass++;
        end
    endtask

    task automatic test_basic();
        do_start(0);
        send(16'h0011, 1, 0);
        send(16'h0022, 1, 0);
        send(16'h0033, 1, 0);
        do_stop();
    endtask

    task automatic test_fill();
        do_start(0);
        for (int i = 1; i <= 6; i++) send(16'(i), 1, 0);
        do_stop();
    endtask

    task automatic test_random();
        int n = $urandom_range(1, 9);
        do_start(0);
        for (int i = 0; i < n; i++) send(16'($urandom), $urandom_range(0, 3) != 0, 0);
        send(16'($urandom), 1, 1);
        @(negedge clk);
        in_valid = 0; stop = 0; dump_req = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (bz[k] !== 1'b0) $display("FAIL busy_after_stop_hs[%0d]: got %b want 0", k, bz[k]);
            else pass++;
        end
    endtask

    task automatic test_idle_corner();
        do_start(1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (bz[k] !== 1'b0 || cnt[k] !== 3'(exp_n(k)))
                $display("FAIL start_stop[%0d]: busy %b count %0d want 0 %0d", k, bz[k], cnt[k], exp_n(k));
            else pass++;
        end
        do_start(0);
        do_stop();
    endtask

    task automatic test_reset_mid_log();
        do_start(0);
        send(16'h0aaa, 1, 0);
        send(16'h0bbb, 1, 0);
        @(negedge clk);
        in_valid = 0; n_rst = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({ir[k], dv[k], dl[k], ov[k], bz[k], dd[k], cnt[k]} !== '0)
                $display("FAIL mid_log_reset[%0d]: got %b want 0", k, {ir[k], dv[k], dl[k], ov[k], bz[k], dd[k], cnt[k]});
            else pass++;
        end
        @(negedge clk) n_rst = 1;
        mlog = 0; mq0.delete(); mq1.delete(); mov[0] = 0; mov[1] = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dump(0);
        test_fill();
        test_dump(0);
        test_dump(2);
        for (int r = 0; r < 4; r++) begin
            test_random();
            test_dump(1);
            test_dump(1);
        end
        test_idle_corner();
        test_dump(0);
        test_reset_mid_log();
        test_dump(0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
